// File: rtl/clock_period_meter.sv
// Purpose : measures period and high time of a divided clock in clk cycles, flags lock and stall.
// Latency : a clk_in rise first sampled at edge k reports (valid) after edge k+SYNC_STAGES.
// Backpressure: none; outputs are levels plus a one-cycle valid pulse, consumers must not stall it.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   clk_in     divided clock under measurement (asynchronous, synchronized here)
//   period     clk cycles between the last two rising edges of clk_in
//   high_time  clk cycles clk_in was sampled high within that period
//   valid      one-cycle pulse when period/high_time update
//   locked     last two reported periods were equal
//   timeout    no rising edge for 2^CNT_W-1 cycles
module clock_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Stalling on the step that would make cnt all-ones keeps a reported period <= 2^CNT_W-2.
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}} - CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] high_nxt;
  logic             valid_nxt;
  logic             locked_nxt;
  logic             timeout_nxt;
  logic             have_prev;
  logic             have_prev_nxt;

  // Synchronizer chain; sync_q[0] is the first sampling flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d    <= s;
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d;
  // hcnt never exceeds cnt, so this cannot wrap before the stall check fires.
  assign hcnt_inc = hcnt + {{(CNT_W-1){1'b0}}, s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      locked    <= locked_nxt;
      timeout   <= timeout_nxt;
      have_prev <= have_prev_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hcnt_nxt      = hcnt;
    period_nxt    = period;
    high_nxt      = high_time;
    valid_nxt     = 1'b0;
    locked_nxt    = locked;
    timeout_nxt   = timeout;
    have_prev_nxt = have_prev;

    case (state)
      IDLE: begin
        // First edge only opens a window; nothing to report yet.
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          hcnt_nxt  = CNT_ONE;
          state_nxt = MEASURE;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_nxt    = cnt;
          high_nxt      = hcnt;
          valid_nxt     = 1'b1;
          locked_nxt    = (cnt == period) && have_prev;
          have_prev_nxt = 1'b1;
          cnt_nxt       = CNT_ONE;
          hcnt_nxt      = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          // Counter reaches all-ones: declare stall, keep last report.
          cnt_nxt       = {CNT_W{1'b1}};
          hcnt_nxt      = hcnt_inc;
          state_nxt     = STALLED;
          timeout_nxt   = 1'b1;
          locked_nxt    = 1'b0;
          have_prev_nxt = 1'b0;
        end else begin
          cnt_nxt  = cnt + CNT_ONE;
          hcnt_nxt = hcnt_inc;
        end
      end

      STALLED: begin
        // Recovery edge behaves like a first edge: restart window, no report.
        if (rise) begin
          cnt_nxt     = CNT_ONE;
          hcnt_nxt    = CNT_ONE;
          timeout_nxt = 1'b0;
          state_nxt   = MEASURE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

  localparam int SYNC = 2;
  localparam int NS   = 20000;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic clk_in  = 1'b0;

  logic [15:0] period16, high16;
  logic        valid16, locked16, timeout16;
  logic [3:0]  period4, high4;
  logic        valid4, locked4, timeout4;

  clock_period_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut16 (
    .clk(clk), .reset(reset), .clk_in(clk_in),
    .period(period16), .high_time(high16),
    .valid(valid16), .locked(locked16), .timeout(timeout16)
  );

  clock_period_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset(reset), .clk_in(clk_in),
    .period(period4), .high_time(high4),
    .valid(valid4), .locked(locked4), .timeout(timeout4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int e      = 0;   // index of the most recent clk rising edge
  int base   = 0;   // first edge index whose sample survives the last reset

  // Reference model: works on the clk_in value sampled at each edge.
  // A rise sampled at index j is reported SYNC edges later; a report gives
  // period = distance between rise samples, high_time = high samples in [prev, j).
  bit samp [NS];
  int last_j    [2];
  bit anchor    [2];
  bit have_prev [2];
  int ex_period [2];
  int ex_high   [2];
  bit ex_valid  [2];
  bit ex_locked [2];
  bit ex_timeout[2];
  int maxc      [2] = '{65535, 15};

  logic [34:0] exp16;
  logic [10:0] exp4;
  wire  [34:0] obs16 = {valid16, locked16, timeout16, period16, high16};
  wire  [10:0] obs4  = {valid4, locked4, timeout4, period4, high4};

  function automatic bit smp(input int i);
    if (i < base || i < 0 || i >= NS) return 1'b0;
    return samp[i];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      anchor[k] = 0; have_prev[k] = 0; last_j[k] = 0;
      ex_period[k] = 0; ex_high[k] = 0;
      ex_valid[k] = 0; ex_locked[k] = 0; ex_timeout[k] = 0;
    end
  endtask

  task automatic model_step();
    int  j, p, h;
    bit  r;
    j = e - SYNC;
    r = smp(j) && !smp(j - 1);
    for (int k = 0; k < 2; k++) begin
      ex_valid[k] = 0;
      if (r) begin
        if (anchor[k]) begin
          p = j - last_j[k];
          h = 0;
          for (int i = last_j[k]; i < j; i++) h += int'(smp(i));
          ex_locked[k] = have_prev[k] && (p == ex_period[k]);
          ex_period[k] = p;
          ex_high[k]   = h;
          ex_valid[k]  = 1;
          have_prev[k] = 1;
        end
        ex_timeout[k] = 0;
        anchor[k]     = 1;
        last_j[k]     = j;
      end else if (anchor[k] && (e == last_j[k] + SYNC + maxc[k] - 1)) begin
        // No rise for 2^W-1 cycles since the window opened.
        anchor[k]     = 0;
        ex_timeout[k] = 1;
        ex_locked[k]  = 0;
        have_prev[k]  = 0;
      end
    end
  endtask

  // Drive one sample, advance one edge, update the model, settle 1 time unit.
  task automatic tick(input bit v);
    clk_in = v;
    @(posedge clk);
    e++;
    if (e < NS) samp[e] = v;
    if (!reset) begin
      base = e + 1;
      model_reset();
    end else begin
      model_step();
    end
    exp16 = {ex_valid[0], ex_locked[0], ex_timeout[0], 16'(ex_period[0]), 16'(ex_high[0])};
    exp4  = {ex_valid[1], ex_locked[1], ex_timeout[1], 4'(ex_period[1]), 4'(ex_high[1])};
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    for (int c = 0; c < 21; c++) begin
      tick(c < 18 ? bit'((c / 3) % 2) : 1'b0);
      checks++;
      if (obs16 !== 35'd0 || obs4 !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got16=%h got4=%h want 0", e, obs16, obs4);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_steady();
    int n = 0;
    for (int c = 0; c < 32; c++) begin
      tick(bit'((c % 8) < 4));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL steady edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
      if (valid16) begin
        n++;
        checks++;
        if (n == 1 && (period16 !== 16'd8 || high16 !== 16'd4 || locked16 !== 1'b0)) begin
          errors++;
          $display("FAIL steady_first p=%0d h=%0d l=%b want 8 4 0", period16, high16, locked16);
        end else if (n > 1 && (period16 !== 16'd8 || locked16 !== 1'b1)) begin
          errors++;
          $display("FAIL steady_lock p=%0d l=%b want 8 1", period16, locked16);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL steady_count reports=%0d want 3", n);
    end
  endtask

  task automatic test_duty_change();
    int n = 0;
    for (int c = 0; c < 40; c++) begin
      tick(bit'((c % 10) < 3));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL duty edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
      if (valid16) begin
        n++;
        checks++;
        if (n == 2 && (period16 !== 16'd10 || high16 !== 16'd3 || locked16 !== 1'b0)) begin
          errors++;
          $display("FAIL duty_first p=%0d h=%0d l=%b want 10 3 0", period16, high16, locked16);
        end else if (n == 3 && (period16 !== 16'd10 || locked16 !== 1'b1)) begin
          errors++;
          $display("FAIL duty_lock p=%0d l=%b want 10 1", period16, locked16);
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL duty_count reports=%0d want 4", n);
    end
  endtask

  task automatic test_stall();
    int nv = 0;
    for (int c = 0; c < 25; c++) begin
      tick(1'b0);
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL stall_hold edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
    end
    checks++;
    if (timeout4 !== 1'b1 || locked4 !== 1'b0 || period4 !== 4'd10 || high4 !== 4'd3 || timeout16 !== 1'b0) begin
      errors++;
      $display("FAIL stall_state to4=%b l4=%b p4=%0d h4=%0d to16=%b want 1 0 10 3 0",
               timeout4, locked4, period4, high4, timeout16);
    end
    for (int c = 0; c < 15; c++) begin
      tick(bit'(c < 12 && (c % 6) < 3));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL stall_recover edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
      if (valid4) begin
        nv++;
        checks++;
        if (period4 !== 4'd6 || high4 !== 4'd3 || locked4 !== 1'b0) begin
          errors++;
          $display("FAIL stall_first_report p4=%0d h4=%0d l4=%b want 6 3 0", period4, high4, locked4);
        end
      end
    end
    checks++;
    if (nv != 1 || timeout4 !== 1'b0) begin
      errors++;
      $display("FAIL stall_exit reports=%0d to4=%b want 1 0", nv, timeout4);
    end
  endtask

  task automatic test_latency();
    bit want [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit drv  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) tick(1'b0);
    for (int c = 0; c < 4; c++) begin
      tick(drv[c]);
      checks++;
      if (valid16 !== want[c]) begin
        errors++;
        $display("FAIL latency edge=k+%0d valid=%b want %b", c, valid16, want[c]);
      end
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL latency_model edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
    end
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic test_fastest();
    int  nv   = 0;
    bit  prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(bit'((c % 2) == 0));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL fastest edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
      if (valid16 && prev) begin
        errors++;
        $display("FAIL fastest_spacing edge=%0d back-to-back valid", e);
      end
      if (valid16) begin
        nv++;
        if (nv >= 3) begin
          checks++;
          if (period16 !== 16'd2 || high16 !== 16'd1 || locked16 !== 1'b1) begin
            errors++;
            $display("FAIL fastest_report p=%0d h=%0d l=%b want 2 1 1", period16, high16, locked16);
          end
        end
      end
      prev = valid16;
    end
    checks++;
    if (nv != 9) begin
      errors++;
      $display("FAIL fastest_count reports=%0d want 9", nv);
    end
  endtask

  task automatic test_async_reset();
    int nv = 0;
    for (int c = 0; c < 18; c++) begin
      tick(bit'((c % 8) < 4));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL arst_pre edge=%0d got16=%h exp16=%h", e, obs16, exp16);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs16 !== 35'd0 || obs4 !== 11'd0) begin
      errors++;
      $display("FAIL arst_immediate got16=%h got4=%h want 0", obs16, obs4);
    end
    tick(1'b0);
    tick(1'b0);
    reset = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick(bit'(c < 30 && (c % 10) < 5));
      checks++;
      if (obs16 !== exp16 || obs4 !== exp4) begin
        errors++;
        $display("FAIL arst_post edge=%0d got16=%h exp16=%h got4=%h exp4=%h", e, obs16, exp16, obs4, exp4);
      end
      if (valid16) begin
        nv++;
        checks++;
        if (nv == 1 && (period16 !== 16'd10 || high16 !== 16'd5 || locked16 !== 1'b0)) begin
          errors++;
          $display("FAIL arst_first_report p=%0d h=%0d l=%b want 10 5 0", period16, high16, locked16);
        end
      end
    end
    checks++;
    if (nv != 2) begin
      errors++;
      $display("FAIL arst_count reports=%0d want 2", nv);
    end
  endtask

  task automatic test_random();
    int hi, lo, nv;
    nv = 0;
    for (int w = 0; w < 40; w++) begin
      hi = $urandom_range(1, 6);
      lo = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 24) : $urandom_range(1, 8);
      for (int c = 0; c < hi + lo; c++) begin
        tick(bit'(c < hi));
        checks++;
        if (obs16 !== exp16 || obs4 !== exp4) begin
          errors++;
          $display("FAIL random w=%0d edge=%0d got16=%h exp16=%h got4=%h exp4=%h",
                   w, e, obs16, exp16, obs4, exp4);
        end
        if (valid16) nv++;
      end
    end
    checks++;
    if (nv < 30) begin
      errors++;
      $display("FAIL random_reports reports=%0d want >=30", nv);
    end
  endtask

  initial begin
    model_reset();
    exp16 = '0;
    exp4  = '0;
    test_reset();
    test_steady();
    test_duty_change();
    test_stall();
    test_latency();
    test_fastest();
    test_random();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the slow clock produced by the team's clock divider: it synchronizes the divided clock into the `clk` domain, detects its rising edges and reports period and high time in `clk` cycles. It also flags lock (two consecutive equal periods) and a stall timeout. It sits next to the divider as its in-system checker and drives debug LEDs and displays.

## Interface
- `CNT_W`, 16, width of the cycle counters and of `period` / `high_time`; minimum 4.
- `SYNC_STAGES`, 2, number of synchronizer flops on `clk_in`; minimum 2.
- `clk`  input  1  system clock; all logic uses its rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `clk_in`  input  1  divided clock under measurement; treated as asynchronous.
- `period`  output  CNT_W  `clk` cycles between the last two rising edges of `clk_in`.
- `high_time`  output  CNT_W  `clk` cycles that `clk_in` was sampled high within that period.
- `valid`  output  1  one-cycle pulse when `period` / `high_time` update.
- `locked`  output  1  level; the last two reported periods were equal.
- `timeout`  output  1  level; no rising edge for 2^CNT_W-1 cycles.

## Operation
- `s` is the output of the last synchronizer stage and `s_d` is `s` delayed by one `clk`. A rising edge is detected when `rise = s & ~s_d`.
- The state machine has three states: IDLE (after reset), MEASURE and STALLED.
- IDLE:
  - On `rise`: `cnt` <= 1, `hcnt` <= 1, go to MEASURE.
  - No `valid` is produced, because a first edge gives no complete period.
- MEASURE, cycle without `rise`:
  - `cnt` <= `cnt` + 1.
  - `hcnt` <= `hcnt` + `s`.
- MEASURE, cycle with `rise`:
  - `period` <= `cnt` and `high_time` <= `hcnt`.
  - `valid` <= 1.
  - `locked` <= (`cnt` == current `period`) & `have_prev`.
  - `have_prev` <= 1.
  - `cnt` <= 1 and `hcnt` <= 1.
- Stall: if `cnt` reaches 2^CNT_W-1 in MEASURE without a `rise`:
  - Go to STALLED.
  - `timeout` <= 1, `locked` <= 0, `have_prev` <= 0.
  - `period` and `high_time` hold their last values.
- STALLED, on `rise`:
  - Go to MEASURE, `timeout` <= 0.
  - `cnt` <= 1, `hcnt` <= 1.
  - No `valid`; the first edge after a stall behaves like IDLE.
- Counters never wrap. A stall occurs before any overflow, so `period` ≤ 2^CNT_W-2.
- With a rise every P cycles and H high samples per window: `period` = P and `high_time` = H. Example: a 50 % duty divider with period 2N gives `high_time` = N.
- `clk_in` held constantly high produces no `rise`. This ends in STALLED, or stays in IDLE if no edge was ever seen.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `valid` = 0, `locked` = 0, `timeout` = 0. All synchronizer flops, `s_d`, `cnt`, `hcnt` and `have_prev` = 0. State = IDLE.
- Reset takes effect immediately, without a `clk` edge, including mid-measurement. After release the block behaves as freshly started; the first rise gives no `valid`.
- Latency: a `clk_in` rise first sampled at edge k gives `valid` = 1 after edge k+SYNC_STAGES. That is 3 edges, counting the sampling edge, for the default configuration.
- `valid` is high for exactly one cycle per reported period. Consecutive `valid` pulses are at least 2 cycles apart, because the synchronized signal needs at least one low sample between rises.
- `period`, `high_time` and `locked` change only in the cycle `valid` rises, or on stall/reset. They are stable otherwise.
- `timeout` rises in the cycle after `cnt` reaches 2^CNT_W-1. It clears in the cycle after the next `rise`.

## Test plan
- Reset behaviour: hold `reset` = 0 while toggling `clk_in` every 3 cycles -> all outputs stay 0. Assert `reset` low mid-period -> outputs clear before the next `clk` edge.
- Steady divider, 4 high / 4 low: first rise -> no `valid`. Second rise -> `valid`, `period` = 8, `high_time` = 4, `locked` = 0. Third rise -> `period` = 8, `locked` = 1.
- Duty change from 4/4 to 3/7: first changed window -> `period` = 10, `high_time` = 3, `locked` = 0. Next window -> `locked` = 1.
- Stall with CNT_W = 4: after lock, hold `clk_in` low -> `timeout` = 1 and `locked` = 0 once `cnt` = 15, `period` unchanged. Next rise -> `timeout` = 0, no `valid`. Rise 6 cycles later -> `valid`, `period` = 6, `locked` = 0.
- Latency check: single isolated rise first sampled at edge k (after a prior edge) -> `valid` high exactly in the cycle after edge k+2 (default SYNC_STAGES).
- Fastest input, `clk_in` toggling every `clk` cycle (period 2, high 1) -> `valid` every 2 cycles, `period` = 2, `high_time` = 1, `locked` = 1 from the second report.
